// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one sequential multiplier between
// NUM_REQ clients: grant, restart the unit, run MUL_CYCLES, capture, pulse Done.
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int MUL_CYCLES = 12
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         Req,
  input  logic [NUM_REQ*WIDTH-1:0]   OperandA,
  input  logic [NUM_REQ*WIDTH-1:0]   OperandB,
  output logic [NUM_REQ-1:0]         Grant,
  output logic [NUM_REQ-1:0]         Done,
  output logic [2*WIDTH-1:0]         Result,
  output logic                       Busy,
  output logic                       MulReset,
  output logic                       MulStart,
  output logic [WIDTH-1:0]           MulMultiplicant,
  output logic [WIDTH-1:0]           MulMultiplier,
  input  logic [2*WIDTH-1:0]         MulProduct
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [PW-1:0]        last, last_n, win;
  logic                 found;
  logic [NUM_REQ-1:0]   grant_n, done_n;
  logic [2*WIDTH-1:0]   result_n;
  logic [WIDTH-1:0]     sel_a, sel_b, mcand_n, mplier_n;

  // Search starts just after the previous owner so a held request cannot starve.
  always_comb begin
    found = 1'b0;
    win   = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && Req[PW'((int'(last) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = PW'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        sel_a = OperandA[i*WIDTH +: WIDTH];
        sel_b = OperandB[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    grant_n  = Grant;
    done_n   = '0;
    result_n = Result;
    mcand_n  = MulMultiplicant;
    mplier_n = MulMultiplier;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (found) begin
          state_n  = CLEAR;
          grant_n  = NUM_REQ'(1) << win;
          last_n   = win;
          mcand_n  = sel_a;
          mplier_n = sel_b;
        end
      end
      CLEAR: begin
        state_n = RUN;
        cnt_n   = '0;
      end
      RUN: begin
        if (cnt == CW'(MUL_CYCLES - 1)) state_n = DONE;
        else                            cnt_n   = cnt + CW'(1);
      end
      DONE: begin
        state_n  = IDLE;
        result_n = MulProduct;
        done_n   = Grant;
        grant_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // Unit controls are decoded from the next state so they line up with it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt             <= '0;
      last            <= PW'(NUM_REQ - 1);
      Grant           <= '0;
      Done            <= '0;
      Result          <= '0;
      Busy            <= 1'b0;
      MulReset        <= 1'b0;
      MulStart        <= 1'b0;
      MulMultiplicant <= '0;
      MulMultiplier   <= '0;
    end else begin
      cnt             <= cnt_n;
      last            <= last_n;
      Grant           <= grant_n;
      Done            <= done_n;
      Result          <= result_n;
      Busy            <= (state_n != IDLE);
      MulReset        <= (state_n != CLEAR);
      MulStart        <= (state_n == RUN);
      MulMultiplicant <= mcand_n;
      MulMultiplier   <= mplier_n;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural sequential multiplier, directed
// requests, and a Done-driven scoreboard popping hand-computed results.
module tb_mult_share_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int WIDTH      = 4;
  localparam int MUL_CYCLES = 12;
  localparam int W          = NUM_REQ + 2 * WIDTH;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] op_a = '0;
  logic [NUM_REQ*WIDTH-1:0] op_b = '0;
  logic [NUM_REQ-1:0]       grant, done;
  logic [2*WIDTH-1:0]       result;
  logic                     busy, mul_reset, mul_start;
  logic [WIDTH-1:0]         mul_a, mul_b;
  logic [2*WIDTH-1:0]       mul_product = '0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int mr_low_cnt = 0;
  int mcnt = 0;
  int done_cyc[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
    .Clock(clk), .Reset(rst_n), .Req(req), .OperandA(op_a), .OperandB(op_b),
    .Grant(grant), .Done(done), .Result(result), .Busy(busy),
    .MulReset(mul_reset), .MulStart(mul_start),
    .MulMultiplicant(mul_a), .MulMultiplier(mul_b), .MulProduct(mul_product)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary by 100000ns expected completion");
    $fatal(1, "watchdog expired");
  end

  // Product becomes final only after MUL_CYCLES sampled Start cycles.
  always @(posedge clk) begin
    if (!mul_reset) begin
      mcnt        <= 0;
      mul_product <= '0;
    end else if (mul_start && mcnt < MUL_CYCLES) begin
      mcnt <= mcnt + 1;
      if (mcnt == MUL_CYCLES - 1) mul_product <= mul_a * mul_b;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] expw(input int idx, input int prod);
    logic [W-1:0] e;
    e = '0;
    e[2*WIDTH +: NUM_REQ] = NUM_REQ'(1) << idx;
    e[2*WIDTH-1:0] = (2*WIDTH)'(prod);
    return e;
  endfunction

  task automatic set_op(input int idx, input int a, input int b);
    op_a[idx*WIDTH +: WIDTH] = WIDTH'(a);
    op_b[idx*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while ((exp_q.size() != 0 || busy) && t < 600);
    if (t >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Releases each requester's Req once it has been granted.
  task automatic drop_on_grant(input string name);
    int t;
    t = 0;
    while (req != '0 && t < 300) begin
      @(posedge clk); #1;
      req &= ~grant;
      t++;
    end
    check({name, "_all_granted"}, 32'(req), 0);
  endtask

  task automatic run_single(input string name, input int idx, input int a, input int b,
                            input int prod, input bit drop_mod);
    int k;
    set_op(idx, a, b);
    exp_q.push_back(expw(idx, prod));
    mr_low_cnt = 0;
    req[idx] = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    check({name, "_grant"}, 32'(grant), 32'(NUM_REQ'(1) << idx));
    check({name, "_busy"}, 32'(busy), 1);
    check({name, "_mulreset_low"}, 32'(mul_reset), 0);
    check({name, "_operand_a"}, 32'(mul_a), a);
    if (drop_mod) begin
      @(posedge clk); #1;
      op_a[idx*WIDTH +: WIDTH] = WIDTH'(a + 1);
    end
    req[idx] = 1'b0;
    wait_idle(name);
    if (done_cyc.size() > 0) check({name, "_latency"}, done_cyc[$] - k, MUL_CYCLES + 2);
    else check({name, "_latency"}, 32'hffff_ffff, MUL_CYCLES + 2);
    check({name, "_mulreset_cycles"}, mr_low_cnt, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && !mul_reset) mr_low_cnt++;
    if (rst_n && done != '0) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      check("done_onehot", 32'($onehot(done)), 1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=%b expected none", done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_owner", 32'(done), 32'(mon_e[2*WIDTH +: NUM_REQ]));
        check("result", 32'(result), 32'(mon_e[2*WIDTH-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int target;
    int t;
    #1 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          32'({grant, done, result, busy, mul_reset, mul_start, mul_a, mul_b}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_mulreset", 32'(mul_reset), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_grant", 32'(grant), 0);

    run_single("single_r0", 0, 13, 13, 169, 1'b0);
    run_single("single_r2", 2, 9, 11, 99, 1'b0);
    run_single("drop_r3", 3, 10, 12, 120, 1'b1);

    // All four at once from pointer 3: order 0,1,2,3 with one idle cycle between.
    set_op(0, 2, 2); set_op(1, 5, 8); set_op(2, 3, 14); set_op(3, 15, 15);
    exp_q.push_back(expw(0, 4));
    exp_q.push_back(expw(1, 40));
    exp_q.push_back(expw(2, 42));
    exp_q.push_back(expw(3, 225));
    n0 = done_cyc.size();
    req = 4'b1111;
    drop_on_grant("all4");
    wait_idle("all4");
    for (int i = 1; i < 4; i++) begin
      if (done_cyc.size() >= n0 + 4) check("all4_spacing", done_cyc[n0+i] - done_cyc[n0+i-1], MUL_CYCLES + 3);
      else check("all4_spacing", done_cyc.size(), n0 + 4);
    end

    // Two requests held continuously must alternate.
    set_op(0, 2, 3); set_op(2, 4, 5);
    exp_q.push_back(expw(0, 6));
    exp_q.push_back(expw(2, 20));
    exp_q.push_back(expw(0, 6));
    exp_q.push_back(expw(2, 20));
    target = done_cnt + 4;
    req = 4'b0101;
    t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    req = '0;
    wait_idle("alternate");

    // Reset in the middle of RUN, then the pointer must restart from NUM_REQ-1.
    set_op(2, 3, 5);
    req[2] = 1'b1;
    @(posedge clk); #1;
    req = '0;
    repeat (6) @(posedge clk);
    #1;
    check("midrun_start", 32'(mul_start), 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          32'({grant, done, result, busy, mul_reset, mul_start, mul_a, mul_b}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_result", 32'(result), 0);
    set_op(1, 7, 6); set_op(3, 9, 9);
    exp_q.push_back(expw(1, 42));
    exp_q.push_back(expw(3, 81));
    req = 4'b1010;
    drop_on_grant("post_reset");
    wait_idle("post_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
